// File: rtl/status_event_queue.sv
// status_event_queue
//   Debounces a raw status vector and queues an event each time a new stable
//   value is committed. Each event carries the committed value, the bits that
//   changed relative to the previous committed value, and a 4-bit sequence
//   number. The sequence number also advances on dropped events, so gaps in
//   evt_seq show loss.
//
// Ports
//   sysclk     in   clock, rising edge
//   reset      in   asynchronous, active-low reset
//   status_in  in   raw status vector [STAT_W]
//   enable     in   commit enable (0 = sample and pop only)
//   clr_ovf    in   single-cycle pulse that clears overflow
//   evt_valid  out  queue head holds an event
//   evt_ready  in   consumer accepts the head event
//   evt_data   out  committed value of the head event [STAT_W]
//   evt_delta  out  changed bits of the head event [STAT_W]
//   evt_seq    out  sequence number of the head event [4]
//   level      out  number of queued events [clog2(DEPTH)+1]
//   overflow   out  sticky flag, an event was dropped
module status_event_queue #(
  parameter int unsigned STAT_W = 9,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned STABLE = 3
) (
  input  logic                     sysclk,
  input  logic                     reset,
  input  logic [STAT_W-1:0]        status_in,
  input  logic                     enable,
  input  logic                     clr_ovf,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [STAT_W-1:0]        evt_data,
  output logic [STAT_W-1:0]        evt_delta,
  output logic [3:0]               evt_seq,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [3:0]       STABLE_C  = 4'(STABLE);
  localparam logic [3:0]       STABLE_M1 = 4'(STABLE - 1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);

  typedef struct packed {
    logic [STAT_W-1:0] data;
    logic [STAT_W-1:0] delta;
    logic [3:0]        seq;
  } evt_t;

  logic [STAT_W-1:0] sample_q;
  logic [STAT_W-1:0] committed;
  logic [3:0]        cnt;
  logic [3:0]        seq_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  evt_t mem [DEPTH];
  evt_t new_evt;
  evt_t head;

  logic commit;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // cnt saturates at STABLE, so ">=" rather than "==" lets a value that
  // stayed stable while enable was low commit on the first enabled edge.
  // For a freshly captured value the first edge that satisfies it is still
  // the one where cnt has just reached STABLE-1, so latency is unchanged.
  always_comb begin
    commit  = (status_in == sample_q) && (cnt >= STABLE_M1) &&
              (sample_q != committed) && enable;
    full    = (level == FULL_LVL);
    evt_valid = (level != '0);
    pop     = evt_valid && evt_ready;
    push    = commit && (!full || pop);
    drop    = commit && full && !pop;
    new_evt = '{data: sample_q, delta: sample_q ^ committed, seq: seq_cnt};
  end

  // Outputs are forced to zero while empty, so stale storage never shows.
  always_comb begin
    head      = mem[rd_ptr];
    evt_data  = evt_valid ? head.data  : '0;
    evt_delta = evt_valid ? head.delta : '0;
    evt_seq   = evt_valid ? head.seq   : '0;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sample_q  <= '0;
      cnt       <= STABLE_C;
      committed <= '0;
      seq_cnt   <= '0;
    end else begin
      sample_q <= status_in;
      if (status_in != sample_q)
        cnt <= '0;
      else if (cnt < STABLE_C)
        cnt <= cnt + 4'd1;
      // committed and seq_cnt advance even when the event itself is dropped
      if (commit) begin
        committed <= sample_q;
        seq_cnt   <= seq_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge sysclk) begin
    if (push)
      mem[wr_ptr] <= new_evt;
  end

endmodule

// File: tb/tb_status_event_queue.sv
module tb_status_event_queue;

  logic       sysclk;
  logic       reset;
  logic [8:0] status_in;
  logic       enable;
  logic       clr_ovf;
  logic       evt_valid;
  logic       evt_ready;
  logic [8:0] evt_data;
  logic [8:0] evt_delta;
  logic [3:0] evt_seq;
  logic [2:0] level;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  status_event_queue #(
    .STAT_W(9),
    .DEPTH (4),
    .STABLE(3)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .status_in(status_in),
    .enable   (enable),
    .clr_ovf  (clr_ovf),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_data (evt_data),
    .evt_delta(evt_delta),
    .evt_seq  (evt_seq),
    .level    (level),
    .overflow (overflow)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [8:0] d,
                            input logic [8:0] dl, input logic [3:0] s);
    check({tag, "_valid"}, 32'(evt_valid), 1);
    check({tag, "_data"},  32'(evt_data),  32'(d));
    check({tag, "_delta"}, 32'(evt_delta), 32'(dl));
    check({tag, "_seq"},   32'(evt_seq),   32'(s));
  endtask

  logic [8:0] bp_vals   [5] = '{9'h001, 9'h003, 9'h007, 9'h00F, 9'h01F};
  logic [8:0] fill_vals [4] = '{9'h040, 9'h041, 9'h043, 9'h047};
  logic [8:0] rst_vals  [3] = '{9'h0C6, 9'h0C4, 9'h0C0};

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    status_in = '0;
    enable    = 1'b1;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;

    // reset state
    repeat (3) tick();
    check("rst_level", 32'(level), 0);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_ovf",   32'(overflow), 0);
    check("rst_data",  32'(evt_data), 0);
    check("rst_delta", 32'(evt_delta), 0);
    check("rst_seq",   32'(evt_seq), 0);
    reset = 1'b1;
    repeat (2) tick();

    // glitches of 2 and STABLE cycles: no event
    for (int len = 2; len <= 3; len++) begin
      status_in = 9'h001;
      repeat (len) tick();
      status_in = 9'h000;
      repeat (6) begin
        tick();
        check("glitch_valid", 32'(evt_valid), 0);
      end
      check("glitch_level", 32'(level), 0);
    end

    // single change, ready high on the commit edge into an empty queue
    status_in = 9'h0A5;
    evt_ready = 1'b1;
    repeat (3) begin
      tick();
      check("single_early", 32'(evt_valid), 0);
    end
    tick();
    check_head("single", 9'h0A5, 9'h0A5, 4'd0);
    check("single_level", 32'(level), 1);
    tick();
    check("single_popped", 32'(evt_valid), 0);
    check("single_level0", 32'(level), 0);
    evt_ready = 1'b0;

    // fresh start for backpressure / overflow
    status_in = 9'h000;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    foreach (bp_vals[i]) begin
      status_in = bp_vals[i];
      repeat (5) tick();
    end
    check("bp_level", 32'(level), 4);
    check("bp_ovf",   32'(overflow), 1);
    check_head("bp_head0", 9'h001, 9'h001, 4'd0);
    repeat (2) begin
      tick();
      check_head("bp_hold", 9'h001, 9'h001, 4'd0);
    end
    evt_ready = 1'b1;
    tick();
    check_head("bp_head1", 9'h003, 9'h002, 4'd1);
    tick();
    check_head("bp_head2", 9'h007, 9'h004, 4'd2);
    tick();
    check_head("bp_head3", 9'h00F, 9'h008, 4'd3);
    tick();
    check("bp_drained", 32'(level), 0);
    evt_ready = 1'b0;
    status_in = 9'h03F;
    repeat (4) tick();
    check_head("bp_after", 9'h03F, 9'h020, 4'd5);
    check("bp_ovf_sticky", 32'(overflow), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("bp_ovf_clr", 32'(overflow), 0);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("bp_level0", 32'(level), 0);

    // full queue with commit and pop on the same edge
    foreach (fill_vals[i]) begin
      status_in = fill_vals[i];
      repeat (5) tick();
    end
    check("full_level", 32'(level), 4);
    check_head("full_head0", 9'h040, 9'h07F, 4'd6);
    status_in = 9'h0C7;
    repeat (3) tick();
    check("full_pre", 32'(level), 4);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("full_same_level", 32'(level), 4);
    check("full_same_ovf",   32'(overflow), 0);
    check_head("full_head1", 9'h041, 9'h001, 4'd7);
    evt_ready = 1'b1;
    tick();
    check_head("full_head2", 9'h043, 9'h002, 4'd8);
    tick();
    check_head("full_head3", 9'h047, 9'h004, 4'd9);
    tick();
    check_head("full_tail", 9'h0C7, 9'h080, 4'd10);
    tick();
    check("full_drained", 32'(level), 0);
    repeat (2) begin
      tick();
      check("empty_ready_level", 32'(level), 0);
      check("empty_ready_valid", 32'(evt_valid), 0);
    end
    evt_ready = 1'b0;

    // reset mid-operation with three events queued
    foreach (rst_vals[i]) begin
      status_in = rst_vals[i];
      repeat (5) tick();
    end
    check("mid_level", 32'(level), 3);
    check_head("mid_head", 9'h0C6, 9'h001, 4'd11);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_valid", 32'(evt_valid), 0);
    check("mid_rst_ovf",   32'(overflow), 0);
    check("mid_rst_data",  32'(evt_data), 0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) begin
      tick();
      check("post_rst_early", 32'(evt_valid), 0);
    end
    tick();
    check_head("post_rst", 9'h0C0, 9'h0C0, 4'd0);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("post_rst_level0", 32'(level), 0);

    // enable gating
    enable    = 1'b0;
    status_in = 9'h100;
    repeat (8) begin
      tick();
      check("gate_valid", 32'(evt_valid), 0);
    end
    enable = 1'b1;
    tick();
    check_head("gate_evt", 9'h100, 9'h1C0, 4'd1);
    check("gate_level", 32'(level), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
